dac_serial_tx: RTL and testbench

Serial transmitter for the equalizer's output path. It accepts a 12-bit filtered sample on a valid/ready handshake and shifts it to the external 12-bit DAC as one 16-bit frame on Sync / Sclk_DAC / Data_DAC. It is the counterpart of the ADC serial receiver: that block turns CS-framed serial bits into samples, and this block turns samples back into Sync-framed serial bits. It sits between the filter bank output and the board DAC pins.

---
 rtl/dac_tx_pkg.sv | 20 ++
 rtl/dac_serial_tx_sclk_tick_gen.sv | 29 ++
 rtl/dac_serial_tx.sv | 98 +++++++++
 tb/tb_dac_serial_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_tx_pkg.sv
// Shared types and constants for the DAC serial transmitter.
package dac_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4
    } dac_state_e;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned SAMPLE_BITS = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

endpackage

// File: rtl/dac_serial_tx_sclk_tick_gen.sv
// Phase timer: ticks on the last cycle of a CLK_DIV (or 2*CLK_DIV when hold) long phase.
module sclk_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock_In,
    input  logic Reset,
    input  logic reload,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d, limit;

    assign limit = hold ? CW'(2 * CLK_DIV - 1) : CW'(CLK_DIV - 1);
    assign tick  = !reload && (cnt_q == limit);
    // Every tick ends a phase, so the count restarts at each state change.
    assign cnt_d = (reload || tick) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clock_In or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_serial_tx.sv
// Serialises 12-bit samples into 16-bit Sync-framed words for the board DAC.
module dac_serial_tx
    import dac_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                   clock_In,
    input  logic                   Reset,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    input  logic [1:0]             mode_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   Sync,
    output logic                   Sclk_DAC,
    output logic                   Data_DAC,
    output logic                   done,
    output logic [SAMPLE_BITS-1:0] Dac
);

    dac_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [3:0]             bit_q, bit_d;
    logic [SAMPLE_BITS-1:0] sample_q, sample_d;
    logic                   tick;

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock_In (clock_In),
        .Reset    (Reset),
        .reload   (state_q == ST_IDLE),
        .hold     (state_q == ST_HOLD),
        .tick     (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        sample_d = sample_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    state_d  = ST_SETUP;
                    shift_d  = {2'b00, mode_in, sample_in};
                    sample_d = sample_in;
                    bit_d    = '0;
                end
            end
            ST_SETUP: if (tick) state_d = ST_LOW;
            ST_LOW: begin
                if (tick) begin
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_HIGH;
                        bit_d   = bit_q + 4'd1;
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_HIGH: if (tick) state_d = ST_LOW;
            ST_HOLD: if (tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state register.
    always_ff @(posedge clock_In or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_q        <= '0;
            sample_q     <= '0;
            sample_ready <= 1'b1;
            Sync         <= 1'b1;
            Sclk_DAC     <= 1'b1;
            Data_DAC     <= 1'b0;
            done         <= 1'b0;
            Dac          <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            sample_q     <= sample_d;
            sample_ready <= (state_d == ST_IDLE);
            Sync         <= (state_d == ST_IDLE) || (state_d == ST_HOLD);
            Sclk_DAC     <= (state_d != ST_LOW);
            Data_DAC     <= ((state_d == ST_SETUP) || (state_d == ST_LOW) ||
                             (state_d == ST_HIGH)) && shift_d[FRAME_BITS-1];
            done         <= (state_q == ST_HOLD) && (state_d == ST_IDLE);
            if ((state_q == ST_HOLD) && (state_d == ST_IDLE)) begin
                Dac <= sample_q;
            end
        end
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx at CLK_DIV=4 and CLK_DIV=1.
module tb_dac_serial_tx;

    logic        clk, rst_n, sel, valid;
    logic [11:0] sample;
    logic [1:0]  mode;

    logic        rdy4, sync4, sclk4, data4, done4;
    logic [11:0] dac4;
    logic        rdy1, sync1, sclk1, data1, done1;
    logic [11:0] dac1;

    logic        obs_rdy, obs_sync, obs_sclk, obs_data, obs_done;
    logic [11:0] obs_dac;

    int checks = 0;
    int errors = 0;

    dac_serial_tx #(.CLK_DIV(4)) dut4 (
        .clock_In (clk), .Reset (rst_n), .sample_in (sample), .mode_in (mode),
        .sample_valid (valid && !sel), .sample_ready (rdy4), .Sync (sync4),
        .Sclk_DAC (sclk4), .Data_DAC (data4), .done (done4), .Dac (dac4)
    );

    dac_serial_tx #(.CLK_DIV(1)) dut1 (
        .clock_In (clk), .Reset (rst_n), .sample_in (sample), .mode_in (mode),
        .sample_valid (valid && sel), .sample_ready (rdy1), .Sync (sync1),
        .Sclk_DAC (sclk1), .Data_DAC (data1), .done (done1), .Dac (dac1)
    );

    assign obs_rdy  = sel ? rdy1  : rdy4;
    assign obs_sync = sel ? sync1 : sync4;
    assign obs_sclk = sel ? sclk1 : sclk4;
    assign obs_data = sel ? data1 : data4;
    assign obs_done = sel ? done1 : done4;
    assign obs_dac  = sel ? dac1  : dac4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start(input logic [11:0] s, input logic [1:0] m);
        @(negedge clk);
        sample = s;
        mode   = m;
        valid  = 1'b1;
    endtask

    // Called during cycle 0 (handshake visible). hm: 0 drop valid, 1 hold valid with
    // next_s, 2 toggle sample_in every cycle, 3 ignored pulse of 12'h123 at cycle 50.
    task automatic do_frame(input string tag, input int hm, input logic [11:0] next_s,
                            input logic [15:0] exp_frame, input logic [11:0] exp_dac);
        int          d;
        int          nb, sfirst, slow, dcyc, stab, last_fall, last_chg;
        logic [15:0] bits;
        logic [11:0] dac_v;
        logic        rdy_v, prev_sclk, prev_data;
        d = sel ? 1 : 4;
        nb = 0; sfirst = -1; slow = 0; dcyc = -1; stab = 0;
        last_fall = -1000; last_chg = -1000;
        bits = '0; dac_v = '0; rdy_v = 1'b0;
        prev_sclk = obs_sclk;
        prev_data = obs_data;
        for (int cyc = 1; cyc <= 40 * d + 10 && dcyc < 0; cyc++) begin
            @(posedge clk);
            #1;
            case (hm)
                1: begin valid = 1'b1; sample = next_s; end
                2: begin valid = 1'b0; sample = ~sample; end
                3: begin valid = (cyc == 50); if (cyc == 50) sample = 12'h123; end
                default: valid = 1'b0;
            endcase
            @(negedge clk);
            if (obs_data !== prev_data) begin
                if (cyc - last_fall < d) stab++;
                last_chg = cyc;
            end
            if (prev_sclk && !obs_sclk && !obs_sync) begin
                bits = {bits[14:0], obs_data};
                nb++;
                if (cyc - last_chg < d) stab++;
                last_fall = cyc;
            end
            if (!obs_sync) begin
                if (sfirst < 0) sfirst = cyc;
                slow++;
            end
            if (obs_done) begin
                dcyc  = cyc;
                dac_v = obs_dac;
                rdy_v = obs_rdy;
            end
            prev_sclk = obs_sclk;
            prev_data = obs_data;
        end
        chk({tag, " sync_first"}, sfirst, 1);
        chk({tag, " sync_low_cycles"}, slow, 32 * d);
        chk({tag, " fall_count"}, nb, 16);
        chk({tag, " frame_bits"}, {16'h0, bits}, {16'h0, exp_frame});
        chk({tag, " done_cycle"}, dcyc, 1 + 34 * d);
        chk({tag, " dac"}, {20'h0, dac_v}, {20'h0, exp_dac});
        chk({tag, " ready_at_done"}, {31'h0, rdy_v}, 32'd1);
        chk({tag, " data_stability"}, stab, 0);
    endtask

    typedef struct {
        logic [11:0] s;
        logic [1:0]  m;
        bit          toggle;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lowc, sclk_low;
        vecs[0] = '{s: 12'hA5C, m: 2'b00, toggle: 1'b0, frame: 16'h0A5C};
        vecs[1] = '{s: 12'h7FF, m: 2'b10, toggle: 1'b1, frame: 16'h27FF};
        vecs[2] = '{s: 12'h000, m: 2'b01, toggle: 1'b0, frame: 16'h1000};
        vecs[3] = '{s: 12'h3C3, m: 2'b00, toggle: 1'b1, frame: 16'h03C3};

        sel = 1'b0; valid = 1'b0; sample = '0; mode = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst ready", {31'h0, obs_rdy}, 32'd1);
        chk("rst sync", {31'h0, obs_sync}, 32'd1);
        chk("rst sclk", {31'h0, obs_sclk}, 32'd1);
        chk("rst data", {31'h0, obs_data}, 32'd0);
        chk("rst done", {31'h0, obs_done}, 32'd0);
        chk("rst dac", {20'h0, obs_dac}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            start(vecs[i].s, vecs[i].m);
            do_frame($sformatf("vec%0d", i), vecs[i].toggle ? 2 : 0, 12'h0,
                     vecs[i].frame, vecs[i].s);
            repeat (3) @(negedge clk);
        end

        // Back-to-back with valid held high; second frame starts at cycle 137.
        start(12'h001, 2'b00);
        do_frame("b2b first", 1, 12'hFFF, 16'h0001, 12'h001);
        do_frame("b2b second", 0, 12'h0, 16'h0FFF, 12'hFFF);

        // Power-down mode with a stray valid pulse mid-frame.
        start(12'h800, 2'b11);
        do_frame("mode hiz", 3, 12'h0, 16'h3800, 12'h800);
        lowc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!obs_sync) lowc++;
        end
        chk("holdoff no_second_frame", lowc, 0);

        // Reset mid-frame at cycle 60 (bit 8 of 16'h0FFF is on the line then).
        start(12'hFFF, 2'b00);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 valid = 1'b0;
        end
        chk("pre_rst sync_low", {31'h0, obs_sync}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst sync", {31'h0, obs_sync}, 32'd1);
        chk("mid_rst sclk", {31'h0, obs_sclk}, 32'd1);
        chk("mid_rst data", {31'h0, obs_data}, 32'd0);
        chk("mid_rst dac", {20'h0, obs_dac}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        sclk_low = 0; lowc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!obs_sclk) sclk_low++;
            if (!obs_rdy) lowc++;
        end
        chk("post_rst sclk_pulses", sclk_low, 0);
        chk("post_rst not_ready", lowc, 0);
        start(12'h3C3, 2'b01);
        do_frame("post_rst", 0, 12'h0, 16'h13C3, 12'h3C3);

        // CLK_DIV=1 instance.
        @(negedge clk) sel = 1'b1;
        start(12'h5A5, 2'b00);
        do_frame("div1", 0, 12'h0, 16'h05A5, 12'h5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
